// File: rtl/pipe_stall_ctrl_if.sv
// Hazard/stall control bundle between the 5-stage pipeline (master) and the
// stall sequencer (slave), plus read-only debug visibility of the sequencer state.
interface pipe_stall_ctrl_if #(
   parameter int CW = 4
);
   // No valid/ready handshake here: every request is a level that its source keeps
   // asserted until the condition clears; every response is a same-cycle level,
   // except mdu_go/mdu_abort, which are single-cycle pulses.
   logic          load_depen;
   logic          mdu_req;
   logic          ex_redirect;
   logic          dmem_wait;
   logic          perf_clr;

   logic          wpcir;
   logic          bubble;
   logic          flush_ifid;
   logic          freeze;
   logic          mdu_go;
   logic          mdu_abort;
   logic          busy;
   logic [31:0]   stall_cnt;
   logic [31:0]   flush_cnt;

   logic          dbg_state;
   logic [CW-1:0] dbg_cnt;

   modport master (
      output load_depen, mdu_req, ex_redirect, dmem_wait, perf_clr,
      input  wpcir, bubble, flush_ifid, freeze, mdu_go, mdu_abort, busy,
      input  stall_cnt, flush_cnt, dbg_state, dbg_cnt
   );

   modport slave (
      input  load_depen, mdu_req, ex_redirect, dmem_wait, perf_clr,
      output wpcir, bubble, flush_ifid, freeze, mdu_go, mdu_abort, busy,
      output stall_cnt, flush_cnt, dbg_state, dbg_cnt
   );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard sequencer: merges load-use, redirect, dmem wait and MDU latency
// into one stall/flush schedule, with stall and flush performance counters.
module pipe_stall_ctrl #(
   parameter int MDU_LAT = 4,
   parameter int CW      = 4
) (
   input  logic              clk,
   input  logic              clrn,
   pipe_stall_ctrl_if.slave  bus
);
   typedef enum logic [0:0] {
      ST_RUN = 1'b0,
      ST_MDU = 1'b1
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   stall_cnt_q, stall_cnt_d;
   logic [31:0]   flush_cnt_q, flush_cnt_d;

   logic wpcir, bubble, flush_ifid, freeze, mdu_go, mdu_abort, busy;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wpcir      = 1'b1;
      bubble     = 1'b0;
      flush_ifid = 1'b0;
      freeze     = 1'b0;
      mdu_go     = 1'b0;
      mdu_abort  = 1'b0;
      busy       = 1'b0;
      // While reset is held the outputs are pinned to their idle values.
      if (clrn) begin
         case (state_q)
            ST_RUN: begin
               if (bus.dmem_wait) begin
                  freeze = 1'b1;
                  wpcir  = 1'b0;
               end else if (bus.ex_redirect) begin
                  flush_ifid = 1'b1;
                  bubble     = 1'b1;
               end else if (bus.mdu_req) begin
                  wpcir   = 1'b0;
                  bubble  = 1'b1;
                  mdu_go  = 1'b1;
                  cnt_d   = CW'(MDU_LAT - 1);
                  state_d = ST_MDU;
               end else if (bus.load_depen) begin
                  wpcir  = 1'b0;
                  bubble = 1'b1;
               end
            end
            ST_MDU: begin
               busy = 1'b1;
               if (bus.dmem_wait) begin
                  freeze = 1'b1;
                  wpcir  = 1'b0;
               end else if (bus.ex_redirect) begin
                  mdu_abort  = 1'b1;
                  flush_ifid = 1'b1;
                  bubble     = 1'b1;
                  cnt_d      = '0;
                  state_d    = ST_RUN;
               end else if (cnt_q > CW'(1)) begin
                  wpcir  = 1'b0;
                  bubble = 1'b1;
                  cnt_d  = cnt_q - CW'(1);
               end else begin
                  // Release cycle: the MDU op finally moves into EX.
                  cnt_d   = '0;
                  state_d = ST_RUN;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (bus.perf_clr) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (!wpcir && !freeze) stall_cnt_d = stall_cnt_q + 32'd1;
         if (flush_ifid)        flush_cnt_d = flush_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q     <= ST_RUN;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.wpcir      = wpcir;
   assign bus.bubble     = bubble;
   assign bus.flush_ifid = flush_ifid;
   assign bus.freeze     = freeze;
   assign bus.mdu_go     = mdu_go;
   assign bus.mdu_abort  = mdu_abort;
   assign bus.busy       = busy;
   assign bus.stall_cnt  = stall_cnt_q;
   assign bus.flush_cnt  = flush_cnt_q;
   assign bus.dbg_state  = state_q;
   assign bus.dbg_cnt    = cnt_q;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: a vector table walks the main scenarios,
// hand-written sequences cover counter wrap and reset mid-MDU.
module tb_pipe_stall_ctrl;
   localparam int MDU_LAT = 4;
   localparam int CW      = 4;
   localparam int NV      = 29;

   logic clk;
   logic clrn;

   pipe_stall_ctrl_if #(.CW(CW)) bus ();

   pipe_stall_ctrl #(.MDU_LAT(MDU_LAT), .CW(CW)) dut (
      .clk  (clk),
      .clrn (clrn),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // in:  {load_depen, mdu_req, ex_redirect, dmem_wait, perf_clr}
   // out: {wpcir, bubble, flush_ifid, freeze, mdu_go, mdu_abort, busy}
   // cnt: MDU countdown value during the vector (before the edge)
   typedef struct {
      logic [4:0] in;
      logic [6:0] out;
      logic [3:0] cnt;
   } vec_t;

   vec_t        vecs [NV];
   int          n_checks;
   int          n_errors;
   logic [31:0] exp_stall;
   logic [31:0] exp_flush;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [4:0] in);
      bus.load_depen  = in[4];
      bus.mdu_req     = in[3];
      bus.ex_redirect = in[2];
      bus.dmem_wait   = in[1];
      bus.perf_clr    = in[0];
   endtask

   function automatic logic [6:0] outs();
      return {bus.wpcir, bus.bubble, bus.flush_ifid, bus.freeze,
              bus.mdu_go, bus.mdu_abort, bus.busy};
   endfunction

   task automatic apply(input int idx, input vec_t v);
      @(negedge clk);
      drive(v.in);
      #2;
      check($sformatf("v%0d_outs", idx), 32'(outs()), 32'(v.out));
      check($sformatf("v%0d_cnt", idx), 32'(bus.dbg_cnt), 32'(v.cnt));
      check($sformatf("v%0d_stall_cnt", idx), bus.stall_cnt, exp_stall);
      check($sformatf("v%0d_flush_cnt", idx), bus.flush_cnt, exp_flush);
      if (v.in[0]) begin
         exp_stall = '0;
         exp_flush = '0;
      end else begin
         if (!v.out[6] && !v.out[3]) exp_stall = exp_stall + 32'd1;
         if (v.out[4])               exp_flush = exp_flush + 32'd1;
      end
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      exp_stall = '0;
      exp_flush = '0;

      // load-use
      vecs[0]  = '{5'b00000, 7'b1000000, 4'd0};
      vecs[1]  = '{5'b10000, 7'b0100000, 4'd0};
      vecs[2]  = '{5'b00000, 7'b1000000, 4'd0};
      // MDU op held from t0, release at t3
      vecs[3]  = '{5'b01000, 7'b0100100, 4'd0};
      vecs[4]  = '{5'b01000, 7'b0100001, 4'd3};
      vecs[5]  = '{5'b01000, 7'b0100001, 4'd2};
      vecs[6]  = '{5'b01000, 7'b1000001, 4'd1};
      vecs[7]  = '{5'b00000, 7'b1000000, 4'd0};
      // redirect during MDU at t1
      vecs[8]  = '{5'b01000, 7'b0100100, 4'd0};
      vecs[9]  = '{5'b00100, 7'b1110011, 4'd3};
      vecs[10] = '{5'b00000, 7'b1000000, 4'd0};
      // redirect + mdu_req + load_depen in RUN
      vecs[11] = '{5'b11100, 7'b1110000, 4'd0};
      vecs[12] = '{5'b00000, 7'b1000000, 4'd0};
      // dmem_wait for 3 cycles during MDU with cnt=2
      vecs[13] = '{5'b01000, 7'b0100100, 4'd0};
      vecs[14] = '{5'b00000, 7'b0100001, 4'd3};
      vecs[15] = '{5'b00010, 7'b0001001, 4'd2};
      vecs[16] = '{5'b00010, 7'b0001001, 4'd2};
      vecs[17] = '{5'b00010, 7'b0001001, 4'd2};
      vecs[18] = '{5'b00000, 7'b0100001, 4'd2};
      vecs[19] = '{5'b00000, 7'b1000001, 4'd1};
      vecs[20] = '{5'b00000, 7'b1000000, 4'd0};
      // dmem_wait holds off a redirect in RUN, then perf_clr with a flush
      vecs[21] = '{5'b00110, 7'b0001000, 4'd0};
      vecs[22] = '{5'b00100, 7'b1110000, 4'd0};
      vecs[23] = '{5'b00101, 7'b1110000, 4'd0};
      vecs[24] = '{5'b00000, 7'b1000000, 4'd0};
      // dmem_wait holds off a redirect in MDU, then abort
      vecs[25] = '{5'b01000, 7'b0100100, 4'd0};
      vecs[26] = '{5'b00110, 7'b0001001, 4'd3};
      vecs[27] = '{5'b00100, 7'b1110011, 4'd3};
      vecs[28] = '{5'b00000, 7'b1000000, 4'd0};

      // reset: outputs pinned even with requests asserted
      clrn = 1'b0;
      drive(5'b01110);
      #2;
      check("rst_outs", 32'(outs()), 32'(7'b1000000));
      check("rst_state", 32'(bus.dbg_state), 32'd0);
      check("rst_stall_cnt", bus.stall_cnt, 32'd0);
      check("rst_flush_cnt", bus.flush_cnt, 32'd0);
      @(negedge clk);
      drive(5'b00000);
      @(negedge clk);
      clrn = 1'b1;

      for (int i = 0; i < NV; i++) apply(i, vecs[i]);

      // stall counter wrap
      @(negedge clk);
      drive(5'b00000);
      force dut.stall_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.stall_cnt_q;
      bus.load_depen = 1'b1;
      #1;
      check("wrap_pre", bus.stall_cnt, 32'hFFFF_FFFF);
      check("wrap_outs", 32'(outs()), 32'(7'b0100000));
      @(negedge clk);
      bus.load_depen = 1'b0;
      #2;
      check("wrap_post", bus.stall_cnt, 32'd0);
      check("wrap_flush_kept", bus.flush_cnt, exp_flush);

      // reset asserted mid-MDU
      @(negedge clk);
      bus.mdu_req = 1'b1;
      #2;
      check("mr_go", 32'(outs()), 32'(7'b0100100));
      @(negedge clk);
      bus.mdu_req = 1'b0;
      #2;
      check("mr_busy", 32'(bus.busy), 32'd1);
      clrn = 1'b0;
      #1;
      check("mr_rst_outs", 32'(outs()), 32'(7'b1000000));
      check("mr_rst_state", 32'(bus.dbg_state), 32'd0);
      check("mr_rst_cnt", 32'(bus.dbg_cnt), 32'd0);
      check("mr_rst_stall", bus.stall_cnt, 32'd0);
      check("mr_rst_flush", bus.flush_cnt, 32'd0);
      @(negedge clk);
      clrn = 1'b1;
      @(negedge clk);
      #2;
      check("mr_after_outs", 32'(outs()), 32'(7'b1000000));
      check("mr_after_stall", bus.stall_cnt, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Pipeline hazard sequencer for the 5-stage CPU. Owns the PC/IF-ID write enable, the ID/EX bubble, the IF-ID flush and the global freeze.
- Combines ID-stage load-use hazards, EX-stage control redirects, data-memory wait and a multi-cycle multiply/divide unit (MDU) into one stall/flush schedule.
- Keeps stall and flush performance counters.

Parameters:
- MDU_LAT, 4: MDU result latency in cycles, counted from the start pulse; legal range 2..16.
- CW, 4: width of the MDU countdown counter; must satisfy 2^CW > MDU_LAT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clrn  in  1  asynchronous active-low reset.
- load_depen  in  1  ID instruction uses a load result still in EX.
- mdu_req  in  1  ID holds a multi-cycle MDU op.
- ex_redirect  in  1  EX resolved a taken branch or jump; PC loads the target this cycle.
- dmem_wait  in  1  data memory not ready; whole pipeline must hold.
- perf_clr  in  1  synchronous clear of both perf counters.
- wpcir  out  1  PC and IF/ID register write enable (1 = advance).
- bubble  out  1  force NOP controls into ID/EX.
- flush_ifid  out  1  load NOP into IF/ID.
- freeze  out  1  hold all pipeline registers, including EX/MEM and MEM/WB.
- mdu_go  out  1  one-cycle MDU start pulse.
- mdu_abort  out  1  one-cycle MDU cancel pulse.
- busy  out  1  controller is in state MDU.
- stall_cnt  out  32  count of cycles with wpcir=0 and freeze=0.
- flush_cnt  out  32  count of cycles with flush_ifid=1.

Behaviour:
- Reset (clrn=0, asynchronous): state=RUN, cnt=0, stall_cnt=0, flush_cnt=0.
- Outputs forced while clrn=0: wpcir=1; bubble, flush_ifid, freeze, mdu_go, mdu_abort, busy all 0.
- Reset asserted mid-MDU drops to RUN with no abort pulse.
- Outputs are combinational from state, cnt and inputs (zero latency). State, cnt and counters are registered.
- States: RUN, MDU.
- Default outputs: wpcir=1; all others 0.
- RUN, first matching rule applies:
  1. dmem_wait: freeze=1, wpcir=0, bubble=0, no state change. A simultaneous redirect is held off until the wait drops (source keeps ex_redirect asserted).
  2. ex_redirect: flush_ifid=1, bubble=1, wpcir=1. Stay in RUN. load_depen and mdu_req are ignored (wrong path).
  3. mdu_req: wpcir=0, bubble=1, mdu_go=1, cnt<=MDU_LAT-1, go to MDU.
  4. load_depen: wpcir=0, bubble=1 for exactly this cycle. Stay in RUN; forwarding covers the next cycle.
- MDU (busy=1), first matching rule applies:
  1. dmem_wait: freeze=1, wpcir=0, cnt holds.
  2. ex_redirect: mdu_abort=1, flush_ifid=1, bubble=1, wpcir=1, cnt<=0, go to RUN.
  3. cnt>1: wpcir=0, bubble=1, cnt<=cnt-1.
  4. cnt==1: release cycle. wpcir=1, bubble=0 (MDU op enters EX), cnt<=0, go to RUN.
- mdu_req and load_depen are ignored in MDU.
- Total stall for an MDU op = MDU_LAT-1 cycles (wpcir=0), excluding freeze cycles.
- Counters:
  - stall_cnt increments when wpcir=0 and freeze=0.
  - flush_cnt increments when flush_ifid=1.
  - Both wrap modulo 2^32.
  - perf_clr has priority: a cleared counter reads 0 next cycle; the same-cycle event is not counted.
- Invariants: flush_ifid=1 implies bubble=1. freeze=1 implies bubble=0 and flush_ifid=0. mdu_go and mdu_abort are never asserted in the same cycle.

Test Plan:
- Load-use: load_depen=1 for 1 cycle in RUN -> wpcir=0, bubble=1 that cycle only; stall_cnt 0->1; state stays RUN.
- MDU op, MDU_LAT=4: mdu_req held high from t0 -> mdu_go=1 at t0; wpcir=0 and bubble=1 at t0..t2; release at t3 (wpcir=1, bubble=0, busy=0 at t4); stall_cnt=3.
- Redirect during MDU at t1 -> mdu_abort=1, flush_ifid=1, bubble=1 at t1; busy=0 at t2; flush_cnt=1; no release cycle.
- dmem_wait 3 cycles during MDU with cnt=2 -> freeze=1, cnt stays 2, stall_cnt unchanged; after wait drops, release occurs 2 cycles later.
- Simultaneous ex_redirect+mdu_req+load_depen in RUN -> only the flush (flush_ifid=1, bubble=1, wpcir=1); mdu_go=0; state RUN.
- Counter edges: preload stall_cnt=32'hFFFFFFFF, stall once -> 0. perf_clr together with a flush -> flush_cnt=0. clrn pulsed low mid-MDU -> RUN, busy=0, counters 0, wpcir=1 immediately.
